// File: rtl/demux_stream.sv
// demux_stream: one-deep registered stream demultiplexer with out-of-range select dropping.
// Define DEMUX_STREAM_ZERO_EN to force demux_out slices of non-valid channels to zero.
module demux_stream #(
    parameter int DAT_WIDTH = 8,
    parameter int SEL_WIDTH = 4,
    parameter int NUM_CH    = 2**SEL_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DAT_WIDTH-1:0]        demux_in,
    input  logic [SEL_WIDTH-1:0]        sel_in,
    input  logic                        in_vld,
    output logic                        in_rdy,
    output logic [NUM_CH*DAT_WIDTH-1:0] demux_out,
    output logic [NUM_CH-1:0]           out_vld,
    input  logic [NUM_CH-1:0]           out_rdy,
    output logic                        err_sel,
    output logic [7:0]                  drop_cnt
);
    localparam int                 LP_SPAN = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] LP_NUM  = (SEL_WIDTH+1)'(NUM_CH);
    logic                 r_vld;
    logic [SEL_WIDTH-1:0] r_ch;
    logic [DAT_WIDTH-1:0] r_dat;
    logic                 r_err;
    logic [7:0]           r_cnt;
    logic [LP_SPAN-1:0]   w_rdy_pad;
    logic                 w_acc;
    logic                 w_ok;
    // Pad ready to the full select span so the held index always addresses a real bit.
    assign w_rdy_pad = LP_SPAN'(out_rdy);
    assign in_rdy    = !r_vld || w_rdy_pad[r_ch];
    assign w_acc     = in_vld && in_rdy;
    assign w_ok      = {1'b0, sel_in} < LP_NUM;
    assign err_sel   = r_err;
    assign drop_cnt  = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_ch  <= '0;
            r_dat <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_acc && w_ok) begin
                r_vld <= 1'b1;
                r_ch  <= sel_in;
                r_dat <= demux_in;
            end else if (in_rdy) begin
                r_vld <= 1'b0;
            end
            if (w_acc && !w_ok) begin
                r_err <= 1'b1;
                r_cnt <= r_cnt + 8'(r_cnt != 8'hff);
            end
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign out_vld[c] = r_vld && (r_ch == SEL_WIDTH'(c));
`ifdef DEMUX_STREAM_ZERO_EN
        assign demux_out[c*DAT_WIDTH +: DAT_WIDTH] = out_vld[c] ? r_dat : '0;
`else
        assign demux_out[c*DAT_WIDTH +: DAT_WIDTH] = r_dat;
`endif
    end
endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 8, the width of one data word.
REQ-002 SHALL have parameter SEL_WIDTH, default 4, the width of the select field.
REQ-003 SHALL have parameter NUM_CH, default 2**SEL_WIDTH, the number of output channels; legal range 2..2**SEL_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port demux_in, input, DAT_WIDTH bits: input data word.
REQ-007 SHALL have port sel_in, input, SEL_WIDTH bits: destination channel index for demux_in.
REQ-008 SHALL have port in_vld, input, 1 bit: demux_in and sel_in are valid.
REQ-009 SHALL have port in_rdy, output, 1 bit: the block accepts the input word this cycle.
REQ-010 SHALL have port demux_out, output, NUM_CH*DAT_WIDTH bits: channel c occupies bits [c*DAT_WIDTH +: DAT_WIDTH].
REQ-011 SHALL have port out_vld, output, NUM_CH bits: valid per channel; at most one bit is set.
REQ-012 SHALL have port out_rdy, input, NUM_CH bits: ready per channel.
REQ-013 SHALL have port err_sel, output, 1 bit: sticky flag, set on any dropped out-of-range select.
REQ-014 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped words.

Function
REQ-015 SHALL accept an input word when in_vld and in_rdy are both 1 in the same cycle.
REQ-016 SHALL use a single output register stage holding data, channel index and a valid bit.
- Latency from accept to out_vld: exactly 1 cycle.
REQ-017 SHALL drive in_rdy = !held_vld || out_rdy[held_ch], so one word per cycle flows while the consumer is ready.
- The out_rdy-to-in_rdy path is combinational.
REQ-018 SHALL set out_vld[held_ch] = held_vld, with all other out_vld bits 0.
REQ-019 SHALL complete an output transfer on channel c when out_vld[c] and out_rdy[c] are both 1.
- If no new word is accepted in that cycle, held_vld clears on the next edge.
REQ-020 SHALL handle a transfer out and a new accept in the same cycle by loading the new word and keeping held_vld at 1 (no bubble).
REQ-021 SHALL keep held data and index stable while out_vld is 1 and out_rdy of that channel is 0.
REQ-022 SHALL ignore out_rdy bits of non-valid channels.
REQ-023 SHALL treat an accepted word with sel_in >= NUM_CH as out-of-range:
- the word is consumed (in_rdy unaffected) and not loaded into the output stage;
- err_sel is set;
- drop_cnt increments, saturating at 255.
REQ-024 SHALL let an out-of-range accept that coincides with an output transfer leave held_vld at 0 on the next edge.
REQ-025 SHALL drive demux_out for every channel from the same held data word, subject to the configuration in REQ-029/REQ-030.

Reset
REQ-026 SHALL, while rst is 1 at a clock edge, clear held_vld, the held index, the held data, err_sel and drop_cnt to 0.
REQ-027 SHALL, from the cycle after reset is applied, drive out_vld all 0 and in_rdy 1; inputs seen during reset are not accepted.
REQ-028 SHALL discard a held word on reset mid-transfer, without delivering it.

Configuration
REQ-029 SHALL, with macro DEMUX_STREAM_ZERO_EN defined, drive demux_out slices of channels whose out_vld bit is 0 to all zeros.
REQ-030 SHALL, without DEMUX_STREAM_ZERO_EN, drive the held data word on every channel slice regardless of out_vld; fewer gates.

Verification
REQ-031 SHALL cover single word: reset, then in_vld=1, sel_in=3, demux_in=0xA5, out_rdy=all 1.
- Next cycle: out_vld=0x0008 and slice 3=0xA5.
- With ZERO_EN: every other slice is 0.
REQ-032 SHALL cover back-pressure: hold out_rdy[3]=0 with a word held on channel 3.
- in_rdy=0 and data stays stable for 5 cycles.
- Raising out_rdy[3] gives a transfer, and in_rdy=1 in that same cycle.
REQ-033 SHALL cover streaming: 16 consecutive words, sel 0..15, all out_rdy=1.
- One out_vld pulse per cycle, in order.
- No bubbles; in_rdy stays 1 throughout.
REQ-034 SHALL cover out-of-range drops: NUM_CH=10, send sel_in=12, then 300 more drops.
- No out_vld asserted.
- err_sel=1; drop_cnt saturates at 255.
REQ-035 SHALL cover reset mid-operation: assert rst while out_vld[5]=1 with out_rdy[5]=0.
- Next cycle: out_vld=0, err_sel=0, drop_cnt=0, in_rdy=1.
